// File: rtl/awgn_pkg.sv
// Shared AWGN-core definitions: datapath widths and the per-stage mantissa bundle
// used by both the normalize and denormalize pipelines.
package awgn_pkg;

    localparam int MANT_W      = 48;
    localparam int SHIFT_W     = 6;
    localparam int FLUSH_SHIFT = 48;

    typedef struct packed {
        logic              valid;
        logic [MANT_W-1:0] mant;
        logic              guard;
        logic              sticky;
    } stage_t;

    localparam stage_t STAGE_IDLE = '{1'b0, 48'd0, 1'b0, 1'b0};

    // Round-to-nearest-even increment: round up above half, or on a tie when the lsb is odd.
    function automatic logic rne_inc(input stage_t s);
        return s.guard & (s.sticky | s.mant[0]);
    endfunction

endpackage

// File: rtl/rshift_sticky48.sv
// Combinational right shift of a 48-bit value by (shamt & MASK), returning the shifted
// value, the last bit shifted out (guard) and the OR of all lower discarded bits (sticky).
module rshift_sticky48
    import awgn_pkg::*;
#(
    parameter logic [SHIFT_W-1:0] MASK = 6'b111111
) (
    input  logic [MANT_W-1:0]  din,
    input  logic [SHIFT_W-1:0] shamt,
    output logic [MANT_W-1:0]  dout,
    output logic               guard,
    output logic               sticky
);

    logic [SHIFT_W-1:0]  amt_s;
    logic [2*MANT_W-1:0] wide_s;

    // Shift into a double-width window so the discarded bits land in the low half.
    always_comb begin
        amt_s  = shamt & MASK;
        wide_s = {din, {MANT_W{1'b0}}} >> amt_s;
        dout   = wide_s[2*MANT_W-1:MANT_W];
        guard  = wide_s[MANT_W-1];
        sticky = |wide_s[MANT_W-2:0];
    end

endmodule

// File: rtl/denorm48_pipe.sv
// Three-stage denormalizer: coarse shift, fine shift, RNE round. Restores a fixed-point
// value from a normalized mantissa and its leading-zero count, with a global-stall handshake.
module denorm48_pipe
    import awgn_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MANT_W-1:0]  in_mant,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MANT_W-1:0]  out_data,
    output logic               out_inexact,
    output logic               out_zero
);

    localparam logic [SHIFT_W-1:0] COARSE_MASK = 6'b110000;
    localparam logic [SHIFT_W-1:0] FINE_MASK   = 6'b001111;

    stage_t             s1_r;
    stage_t             s2_r;
    logic [3:0]         s1_fine_r;

    logic               adv_s;
    logic               live_s;
    logic               flush_s;
    logic [MANT_W-1:0]  mant_in_s;
    logic [SHIFT_W-1:0] shift_in_s;
    logic [MANT_W-1:0]  c_mant_s;
    logic               c_guard_s;
    logic               c_sticky_s;
    logic [MANT_W-1:0]  f_mant_s;
    logic               f_guard_s;
    logic               f_sticky_s;
    stage_t             s1_next_s;
    stage_t             s2_next_s;
    logic [MANT_W-1:0]  sum_s;

    assign adv_s    = ~out_valid | out_ready;
    assign in_ready = adv_s;

    // Operand gating: idle or zero beats carry an all-zero mantissa and shift into the datapath.
    always_comb begin
        live_s     = in_valid & ~in_zero;
        mant_in_s  = live_s ? in_mant : {MANT_W{1'b0}};
        shift_in_s = live_s ? in_shift : {SHIFT_W{1'b0}};
        flush_s    = shift_in_s >= SHIFT_W'(FLUSH_SHIFT);
    end

    rshift_sticky48 #(.MASK(COARSE_MASK)) u_coarse (
        .din    (mant_in_s),
        .shamt  (shift_in_s),
        .dout   (c_mant_s),
        .guard  (c_guard_s),
        .sticky (c_sticky_s)
    );

    // Stage 1 result: a flush (shift >= 48) discards everything into sticky and never rounds up.
    always_comb begin
        s1_next_s.valid = in_valid;
        if (flush_s) begin
            s1_next_s.mant   = {MANT_W{1'b0}};
            s1_next_s.guard  = 1'b0;
            s1_next_s.sticky = |mant_in_s;
        end else begin
            s1_next_s.mant   = c_mant_s;
            s1_next_s.guard  = c_guard_s;
            s1_next_s.sticky = c_sticky_s;
        end
    end

    rshift_sticky48 #(.MASK(FINE_MASK)) u_fine (
        .din    (s1_r.mant),
        .shamt  ({2'b00, s1_fine_r}),
        .dout   (f_mant_s),
        .guard  (f_guard_s),
        .sticky (f_sticky_s)
    );

    // Stage 2 result: a nonzero fine shift demotes the coarse guard into sticky.
    always_comb begin
        s2_next_s.valid = s1_r.valid;
        s2_next_s.mant  = f_mant_s;
        if (s1_fine_r != 4'd0) begin
            s2_next_s.guard  = f_guard_s;
            s2_next_s.sticky = f_sticky_s | s1_r.guard | s1_r.sticky;
        end else begin
            s2_next_s.guard  = s1_r.guard;
            s2_next_s.sticky = s1_r.sticky;
        end
    end

    // Rounding adder; bit47 of the shifted value is clear whenever guard can be set.
    always_comb begin
        sum_s = s2_r.mant + {{(MANT_W-1){1'b0}}, rne_inc(s2_r)};
    end

    // Pipeline registers: all stages advance together, or all hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r        <= STAGE_IDLE;
            s1_fine_r   <= 4'd0;
            s2_r        <= STAGE_IDLE;
            out_valid   <= 1'b0;
            out_data    <= {MANT_W{1'b0}};
            out_inexact <= 1'b0;
            out_zero    <= 1'b0;
        end else if (adv_s) begin
            s1_r        <= s1_next_s;
            s1_fine_r   <= flush_s ? 4'd0 : shift_in_s[3:0];
            s2_r        <= s2_next_s;
            out_valid   <= s2_r.valid;
            out_data    <= sum_s;
            out_inexact <= s2_r.guard | s2_r.sticky;
            out_zero    <= (sum_s == {MANT_W{1'b0}});
        end
    end

endmodule

// File: tb/tb_denorm48_pipe.sv
// Bench for denorm48_pipe: directed vector table, stall and reset sequences, and a
// randomized stream scored against an arithmetic rounding model.
module tb_denorm48_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_mant;
    logic [5:0]  in_shift;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic        out_inexact;
    logic        out_zero;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int pops = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [47:0] mant;
        logic [5:0]  shift;
        logic        zero;
        logic [47:0] data;
        logic        inexact;
        logic        ozero;
    } vec_t;

    typedef struct packed {
        logic [47:0] d;
        logic        ix;
        logic        z;
    } exp_t;

    vec_t vecs[12];
    exp_t sbq[$];

    always #5 clk = ~clk;

    denorm48_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mant     (in_mant),
        .in_shift    (in_shift),
        .in_zero     (in_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_inexact (out_inexact),
        .out_zero    (out_zero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: exact integer division by 2^s with round-half-to-even on the remainder.
    function automatic exp_t ref_model(input logic [47:0] m, input logic [5:0] s, input logic z);
        exp_t r;
        longint unsigned mv, q, rem, half;
        int sh;
        sh = int'(s);
        if (z) begin
            r.d = 48'd0; r.ix = 1'b0;
        end else if (sh >= 48) begin
            r.d = 48'd0; r.ix = (m != 48'd0);
        end else begin
            mv   = 64'(m);
            q    = mv >> sh;
            rem  = mv - (q << sh);
            half = (sh == 0) ? 64'd0 : (64'd1 << (sh - 1));
            if (sh != 0 && (rem > half || (rem == half && q[0]))) q = q + 64'd1;
            r.d  = q[47:0];
            r.ix = (rem != 64'd0);
        end
        r.z = (r.d == 48'd0);
        return r;
    endfunction

    task automatic rand_beat();
        in_mant = {1'b1, 15'($urandom), 32'($urandom)};
        if ($urandom_range(0, 7) == 0) in_mant = {16'($urandom), 32'($urandom)};
        in_shift = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(48, 63)) : 6'($urandom_range(0, 47));
        in_zero  = ($urandom_range(0, 15) == 0);
    endtask

    // Monitor: handshake law, stability under stall, and in-order scoreboard.
    logic [47:0] held_d;
    logic        held_ix, held_z, hold_prev;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !mon_en) begin
            hold_prev = 1'b0;
        end else begin
            check("in_ready law", 64'(in_ready), 64'(!out_valid || out_ready));
            if (hold_prev)
                check("stall hold", {15'd0, out_valid, out_data}, {15'd0, 1'b1, held_d});
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected beat", 64'(out_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("stream result", {14'd0, out_data, out_inexact, out_zero},
                          {14'd0, e.d, e.ix, e.z});
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back(ref_model(in_mant, in_shift, in_zero));
                accepted++;
            end
            hold_prev = out_valid && !out_ready;
            held_d = out_data; held_ix = out_inexact; held_z = out_zero;
        end
    end

    initial begin
        int base_acc, base_pop, stall, cyc;
        bit started;

        vecs[0]  = '{48'h8000_0000_0000, 6'd0,  1'b0, 48'h8000_0000_0000, 1'b0, 1'b0};
        vecs[1]  = '{48'h8000_0000_0003, 6'd1,  1'b0, 48'h4000_0000_0002, 1'b1, 1'b0};
        vecs[2]  = '{48'hC000_0000_0000, 6'd47, 1'b0, 48'h0000_0000_0002, 1'b1, 1'b0};
        vecs[3]  = '{48'h8000_0000_0000, 6'd47, 1'b0, 48'h0000_0000_0001, 1'b0, 1'b0};
        vecs[4]  = '{48'hDEAD_BEEF_1234, 6'd5,  1'b1, 48'h0000_0000_0000, 1'b0, 1'b1};
        vecs[5]  = '{48'h8000_0000_0001, 6'd50, 1'b0, 48'h0000_0000_0000, 1'b1, 1'b1};
        vecs[6]  = '{48'h8000_0000_0000, 6'd48, 1'b0, 48'h0000_0000_0000, 1'b1, 1'b1};
        vecs[7]  = '{48'h8000_0000_8000, 6'd16, 1'b0, 48'h0000_8000_0000, 1'b1, 1'b0};
        vecs[8]  = '{48'h8000_0001_8000, 6'd16, 1'b0, 48'h0000_8000_0002, 1'b1, 1'b0};
        vecs[9]  = '{48'hFFFF_FFFF_FFFF, 6'd1,  1'b0, 48'h8000_0000_0000, 1'b1, 1'b0};
        vecs[10] = '{48'hC000_0000_0001, 6'd63, 1'b0, 48'h0000_0000_0000, 1'b1, 1'b1};
        vecs[11] = '{48'h8000_0000_C000, 6'd20, 1'b0, 48'h0000_0800_0000, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_mant = 48'd0; in_shift = 6'd0; in_zero = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        check("reset out_inexact", 64'(out_inexact), 64'd0);
        check("reset out_zero", 64'(out_zero), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed vectors, one at a time through an empty pipe, with latency check.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_mant = vecs[i].mant; in_shift = vecs[i].shift; in_zero = vecs[i].zero;
            check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk); #1; in_valid = 1'b0;
            @(posedge clk); #1;
            check($sformatf("vec%0d early valid", i), 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d data", i), 64'(out_data), 64'(vecs[i].data));
            check($sformatf("vec%0d inexact", i), 64'(out_inexact), 64'(vecs[i].inexact));
            check($sformatf("vec%0d zero", i), 64'(out_zero), 64'(vecs[i].ozero));
        end
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Six back-to-back beats with a 5-cycle output stall after the first result.
        base_acc = accepted; base_pop = pops; stall = 0; started = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (accepted - base_acc < 6) begin in_valid = 1'b1; rand_beat(); end
            else in_valid = 1'b0;
            if (out_valid) started = 1'b1;
            if (started && stall < 5) begin
                out_ready = 1'b0; stall++; #1;
                check("stall in_ready", 64'(in_ready), 64'd0);
            end else begin
                out_ready = 1'b1;
            end
        end
        check("stall beats out", 64'(pops - base_pop), 64'd6);
        check("stall queue empty", 64'(sbq.size()), 64'd0);

        // Reset with three beats in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1; in_valid = 1'b1; rand_beat();
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0; #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset in_ready", 64'(in_ready), 64'd1);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("post-reset idle", 64'(out_valid), 64'd0);
        end

        // Randomized stream with random backpressure.
        base_acc = accepted; cyc = 0;
        while (accepted - base_acc < 10000 && cyc < 40000) begin
            @(posedge clk); #1; cyc++;
            in_valid  = ($urandom_range(0, 3) != 0);
            rand_beat();
            out_ready = ($urandom_range(0, 3) != 0);
        end
        check("random beat budget", 64'(accepted - base_acc >= 10000), 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
        #1;
        check("final drain", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
